// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Definitions shared between the SRAM controller and the sram_responder model:
// default bus widths, the responder FSM state encodings and the width of the
// read-latency wait counter.
// -----------------------------------------------------------------------------
package sram_pkg;

    // Bus widths shared with the controller side.
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Largest supported read latency. The wait counter only has to hold
    // MAX_READ_LATENCY-2, so three bits are enough.
    localparam int MAX_READ_LATENCY = 8;
    localparam int WAIT_WIDTH       = 3;

    // Responder FSM states.
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_READ_WAIT    = 2'd1;
    localparam logic [1:0] ST_READ_DRIVE   = 2'd2;
    localparam logic [1:0] ST_WRITE_ACTIVE = 2'd3;

endpackage : sram_pkg

// File: rtl/sram_array.sv
// -----------------------------------------------------------------------------
// sram_array
// 2^ADDR_WIDTH x DATA_WIDTH storage with one synchronous write port and one
// synchronous read port. The read port's output register doubles as the
// responder's dataOut register: it loads only when rd_en is high and holds its
// value otherwise.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe; wr_data is stored at wr_addr on the edge
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; mem[rd_addr] is loaded into rd_data on the edge
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module sram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the storage is deliberately left out of reset. Resetting every word
    // would stop it mapping onto block RAM, and the contents must survive a
    // reset pulse anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : sram_array

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Stands in for the physical SRAM opposite the SRAM controller. It answers the
// active-low chip-select / output-enable / write-enable strobes, returns read
// data after READ_LATENCY edges, commits writes when the write strobe ends,
// counts accesses and flags protocol violations.
//
// Ports:
//   clk            in   clock; every input is sampled on the rising edge
//   reset          in   asynchronous active-low reset
//   csBar          in   chip select, active low
//   oeBar          in   output enable, active low
//   weBar          in   write enable, active low
//   latch          in   load addrIn into the address register (IDLE only)
//   addrIn         in   address from the controller
//   dataIn         in   write data from the controller
//   dataOut        out  read data (holds its value after the read ends)
//   dataOutEnable  out  high while dataOut is being driven
//   protoError     out  sticky protocol-violation flag
//   readCount      out  completed reads, saturating
//   writeCount     out  committed writes, saturating
// -----------------------------------------------------------------------------
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 2,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csBar,
    input  logic                   oeBar,
    input  logic                   weBar,
    input  logic                   latch,
    input  logic [ADDR_WIDTH-1:0]  addrIn,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    output logic [DATA_WIDTH-1:0]  dataOut,
    output logic                   dataOutEnable,
    output logic                   protoError,
    output logic [COUNT_WIDTH-1:0] readCount,
    output logic [COUNT_WIDTH-1:0] writeCount
);

    // Value loaded into the wait counter when a read starts. Latency 1 skips
    // READ_WAIT entirely, so the load value is irrelevant there.
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD =
        (READ_LATENCY > 1) ? WAIT_WIDTH'(READ_LATENCY - 2) : '0;

    logic [1:0]             state_d,   state_q;
    logic [ADDR_WIDTH-1:0]  addr_d,    addr_q;
    logic [WAIT_WIDTH-1:0]  wait_d,    wait_q;
    logic [DATA_WIDTH-1:0]  wr_data_d, wr_data_q;
    logic                   doe_d,     doe_q;
    logic                   err_d,     err_q;
    logic [COUNT_WIDTH-1:0] rd_cnt_d,  rd_cnt_q;
    logic [COUNT_WIDTH-1:0] wr_cnt_d,  wr_cnt_q;

    logic mem_we;
    logic mem_re;
    logic enter_drive;
    logic conflict;
    logic read_req;
    logic write_req;
    logic strobe_released;

    always_comb begin
        conflict        = !csBar && !oeBar && !weBar;
        read_req        = !csBar && !oeBar &&  weBar;
        write_req       = !csBar &&  oeBar && !weBar;
        // Any sampled release of a read or write strobe ends the access.
        strobe_released = csBar;
    end

    // NOTE: every signal assigned below gets a default first so that paths not
    // covered by the case statement hold their value instead of inferring a
    // latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        wr_data_d   = wr_data_q;
        doe_d       = doe_q;
        err_d       = err_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        enter_drive = 1'b0;

        // Address latching is only legal between accesses.
        if (latch) begin
            if (state_q == ST_IDLE) begin
                addr_d = addrIn;
            end else begin
                err_d = 1'b1;
            end
        end

        if (conflict) begin
            // Read and write strobes together: abort whatever is in progress.
            // A pending write is simply not committed.
            err_d   = 1'b1;
            doe_d   = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (read_req) begin
                        if (READ_LATENCY == 1) begin
                            enter_drive = 1'b1;
                        end else begin
                            state_d = ST_READ_WAIT;
                            wait_d  = WAIT_LOAD;
                        end
                    end else if (write_req) begin
                        state_d   = ST_WRITE_ACTIVE;
                        wr_data_d = dataIn;
                    end
                end

                ST_READ_WAIT: begin
                    if (strobe_released || oeBar) begin
                        state_d = ST_IDLE;
                    end else if (wait_q == '0) begin
                        enter_drive = 1'b1;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end

                ST_READ_DRIVE: begin
                    if (strobe_released || oeBar) begin
                        doe_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end

                ST_WRITE_ACTIVE: begin
                    if (strobe_released || weBar) begin
                        // Commit the data captured on the last active edge,
                        // not whatever dataIn shows on the release edge.
                        mem_we  = 1'b1;
                        state_d = ST_IDLE;
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end else begin
                        wr_data_d = dataIn;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (enter_drive) begin
            state_d = ST_READ_DRIVE;
            doe_d   = 1'b1;
            mem_re  = 1'b1;
            if (rd_cnt_q != '1) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wait_q    <= '0;
            wr_data_q <= '0;
            doe_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            wr_data_q <= wr_data_d;
            doe_q     <= doe_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // The array's read register is the dataOut register: it is loaded on the
    // edge that enters READ_DRIVE, so latency 1 returns data on the very edge
    // that first samples the strobes.
    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (mem_we),
        .wr_addr (addr_q),
        .wr_data (wr_data_q),
        .rd_en   (mem_re),
        .rd_addr (addr_q),
        .rd_data (dataOut)
    );

    assign dataOutEnable = doe_q;
    assign protoError    = err_q;
    assign readCount     = rd_cnt_q;
    assign writeCount    = wr_cnt_q;

endmodule : sram_responder

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Five responders share one strobe bus: the main instance (latency 2), three
// latency variants (1, 3, 8) and a 2-bit-counter instance for saturation.
// Expected read data is queued when a read is launched and compared by a
// monitor when the main instance raises dataOutEnable.
// -----------------------------------------------------------------------------
module tb_sram_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       csBar, oeBar, weBar, latch;
    logic [7:0] addrIn, dataIn;

    logic [7:0]  dut_dout, l1_dout, l3_dout, l8_dout, sat_dout;
    logic        dut_doe,  l1_doe,  l3_doe,  l8_doe,  sat_doe;
    logic        dut_err,  l1_err,  l3_err,  l8_err,  sat_err;
    logic [15:0] dut_rc, dut_wc, l1_rc, l1_wc, l3_rc, l3_wc, l8_rc, l8_wc;
    logic [1:0]  sat_rc, sat_wc;

    always #5 clk = ~clk;

    sram_responder #(.READ_LATENCY(2), .COUNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .latch(latch), .addrIn(addrIn), .dataIn(dataIn), .dataOut(dut_dout),
        .dataOutEnable(dut_doe), .protoError(dut_err), .readCount(dut_rc),
        .writeCount(dut_wc));

    sram_responder #(.READ_LATENCY(1), .COUNT_WIDTH(16)) u_l1 (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .latch(latch), .addrIn(addrIn), .dataIn(dataIn), .dataOut(l1_dout),
        .dataOutEnable(l1_doe), .protoError(l1_err), .readCount(l1_rc),
        .writeCount(l1_wc));

    sram_responder #(.READ_LATENCY(3), .COUNT_WIDTH(16)) u_l3 (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .latch(latch), .addrIn(addrIn), .dataIn(dataIn), .dataOut(l3_dout),
        .dataOutEnable(l3_doe), .protoError(l3_err), .readCount(l3_rc),
        .writeCount(l3_wc));

    sram_responder #(.READ_LATENCY(8), .COUNT_WIDTH(16)) u_l8 (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .latch(latch), .addrIn(addrIn), .dataIn(dataIn), .dataOut(l8_dout),
        .dataOutEnable(l8_doe), .protoError(l8_err), .readCount(l8_rc),
        .writeCount(l8_wc));

    sram_responder #(.READ_LATENCY(2), .COUNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .csBar(csBar), .oeBar(oeBar), .weBar(weBar),
        .latch(latch), .addrIn(addrIn), .dataIn(dataIn), .dataOut(sat_dout),
        .dataOutEnable(sat_doe), .protoError(sat_err), .readCount(sat_rc),
        .writeCount(sat_wc));

    int checks   = 0;
    int failures = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    logic [7:0] model [256];
    logic [7:0] sb_q [$];
    logic [7:0] mon_exp;
    logic       doe_seen = 1'b0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        csBar = 1'b1;
        oeBar = 1'b1;
        weBar = 1'b1;
        latch = 1'b0;
    endtask

    task automatic do_latch(input logic [7:0] addr);
        latch  = 1'b1;
        addrIn = addr;
        step();
        latch  = 1'b0;
    endtask

    // Write with the final value presented only on the last active edge, and
    // garbage on the release edge, so the commit must use the last capture.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int hold);
        do_latch(addr);
        csBar = 1'b0;
        weBar = 1'b0;
        for (int k = 0; k < hold; k++) begin
            dataIn = (k == hold - 1) ? data : ~data;
            step();
        end
        dataIn = ~data;
        csBar  = 1'b1;
        weBar  = 1'b1;
        step();
        model[addr] = data;
        exp_wr++;
        check("write_count", dut_wc, exp_wr);
        check("sat_write_count", sat_wc, sat3(exp_wr));
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input int hold);
        do_latch(addr);
        sb_q.push_back(exp);
        csBar = 1'b0;
        oeBar = 1'b0;
        repeat (hold) step();
        idle_bus();
        step();
        exp_rd++;
        check("doe_release", dut_doe, 1'b0);
        check("dout_hold", dut_dout, exp);
        check("read_count", dut_rc, exp_rd);
        check("sat_read_count", sat_rc, sat3(exp_rd));
    endtask

    task automatic reset_pulse_checks();
        reset = 1'b0;
        #1;
        check("rst_doe", dut_doe, 1'b0);
        check("rst_dout", dut_dout, 8'h00);
        check("rst_err", dut_err, 1'b0);
        check("rst_rc", dut_rc, 16'd0);
        check("rst_wc", dut_wc, 16'd0);
        idle_bus();
        step();
        reset  = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        step();
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dut_doe && !doe_seen) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_drive: got dataOut 0x%0h with no read pending at %0t",
                         dut_dout, $time);
            end else begin
                mon_exp = sb_q.pop_front();
                check("read_data", dut_dout, mon_exp);
            end
        end
        doe_seen = dut_doe;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{addr: 8'h00, wdata: 8'h3C, hold: 1, exp_rdata: 8'h3C};
        vecs[1] = '{addr: 8'hFF, wdata: 8'h81, hold: 2, exp_rdata: 8'h81};
        vecs[2] = '{addr: 8'h41, wdata: 8'h99, hold: 1, exp_rdata: 8'h99};
        vecs[3] = '{addr: 8'h12, wdata: 8'h5A, hold: 4, exp_rdata: 8'h5A};
        vecs[4] = '{addr: 8'h40, wdata: 8'h00, hold: 3, exp_rdata: 8'h00};

        reset  = 1'b0;
        dataIn = 8'h00;
        addrIn = 8'h00;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("init_doe", dut_doe, 1'b0);
        check("init_dout", dut_dout, 8'h00);
        check("init_err", dut_err, 1'b0);
        check("init_rc", dut_rc, 16'd0);
        check("init_wc", dut_wc, 16'd0);
        check("init_l8_doe", l8_doe, 1'b0);
        check("init_sat_wc", sat_wc, 2'd0);
        reset = 1'b1;
        step();

        // Write 0xA5 to 0x12 over three active edges, then read it back while
        // checking the first valid edge of every latency variant.
        do_write(8'h12, 8'hA5, 3);
        do_latch(8'h12);
        sb_q.push_back(8'hA5);
        csBar = 1'b0;
        oeBar = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("lat1_doe", l1_doe, 1'b1);
            check("lat2_doe", dut_doe, (k >= 2));
            check("lat3_doe", l3_doe, (k >= 3));
            check("lat8_doe", l8_doe, (k >= 8));
        end
        check("lat1_dout", l1_dout, 8'hA5);
        check("lat3_dout", l3_dout, 8'hA5);
        check("lat8_dout", l8_dout, 8'hA5);
        idle_bus();
        step();
        exp_rd++;
        check("sweep_release_doe", dut_doe, 1'b0);
        check("sweep_release_l8_doe", l8_doe, 1'b0);
        check("sweep_dout_hold", dut_dout, 8'hA5);
        check("sweep_rc", dut_rc, exp_rd);

        // Table-driven writes, then read everything back.
        foreach (vecs[i]) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].hold);
        foreach (vecs[i]) do_read(vecs[i].addr, vecs[i].exp_rdata, 3);

        // Write release and read start on the same edge: commit first, read
        // recognised one edge later and sees the new data.
        do_latch(8'h30);
        csBar  = 1'b0;
        weBar  = 1'b0;
        dataIn = 8'h77;
        step();
        weBar  = 1'b1;
        oeBar  = 1'b0;
        dataIn = 8'h00;
        model[8'h30] = 8'h77;
        sb_q.push_back(8'h77);
        step();
        exp_wr++;
        check("b2b_wc", dut_wc, exp_wr);
        check("b2b_no_doe_yet", dut_doe, 1'b0);
        check("b2b_l1_no_doe_yet", l1_doe, 1'b0);
        step();
        check("b2b_l1_doe", l1_doe, 1'b1);
        check("b2b_l1_dout", l1_dout, 8'h77);
        check("b2b_dut_wait", dut_doe, 1'b0);
        step();
        check("b2b_dut_doe", dut_doe, 1'b1);
        idle_bus();
        step();
        exp_rd++;
        check("b2b_rc", dut_rc, exp_rd);

        // Read abandoned in READ_WAIT: no drive, no count.
        do_latch(8'h12);
        csBar = 1'b0;
        oeBar = 1'b0;
        step();
        csBar = 1'b1;
        step();
        oeBar = 1'b1;
        check("abandon_doe", dut_doe, 1'b0);
        check("abandon_rc", dut_rc, exp_rd);
        repeat (2) step();
        check("abandon_doe_later", dut_doe, 1'b0);
        check("abandon_l3_doe", l3_doe, 1'b0);
        check("abandon_l8_doe", l8_doe, 1'b0);
        check("abandon_rc_later", dut_rc, exp_rd);

        // Latch pulse during WRITE_ACTIVE: error, write still lands at 0x40.
        check("err_before_latch", dut_err, 1'b0);
        do_latch(8'h40);
        csBar  = 1'b0;
        weBar  = 1'b0;
        dataIn = 8'hC3;
        step();
        latch  = 1'b1;
        addrIn = 8'h41;
        step();
        latch  = 1'b0;
        check("latch_err", dut_err, 1'b1);
        idle_bus();
        step();
        model[8'h40] = 8'hC3;
        exp_wr++;
        check("latch_wc", dut_wc, exp_wr);
        do_read(8'h40, 8'hC3, 3);
        do_read(8'h41, 8'h99, 3);

        // Reset in the middle of a driven read.
        do_latch(8'h40);
        sb_q.push_back(8'hC3);
        csBar = 1'b0;
        oeBar = 1'b0;
        repeat (3) step();
        check("pre_reset_doe", dut_doe, 1'b1);
        reset_pulse_checks();

        // Reset in the middle of a write: the write is dropped.
        do_latch(8'h12);
        csBar  = 1'b0;
        weBar  = 1'b0;
        dataIn = 8'hEE;
        repeat (2) step();
        reset_pulse_checks();
        check("dropped_wc", dut_wc, 16'd0);
        do_read(8'h12, model[8'h12], 3);
        do_read(8'h40, model[8'h40], 3);

        // Conflict during WRITE_ACTIVE.
        check("err_before_conflict", dut_err, 1'b0);
        do_latch(8'h12);
        csBar  = 1'b0;
        weBar  = 1'b0;
        dataIn = 8'h33;
        step();
        oeBar = 1'b0;
        step();
        check("conflict_err", dut_err, 1'b1);
        check("conflict_wc", dut_wc, exp_wr);
        check("conflict_doe", dut_doe, 1'b0);
        idle_bus();
        step();
        check("conflict_wc_after", dut_wc, exp_wr);
        repeat (3) step();
        check("conflict_err_sticky", dut_err, 1'b1);
        do_read(8'h12, 8'h5A, 3);
        check("conflict_err_final", dut_err, 1'b1);

        repeat (2) step();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sram_responder
